// File: rtl/parity_check_rx_pkg.sv
// Shared definitions for the parity frame path (generator and receiver).
package parity_check_rx_pkg;

  // Frame sequencing states, shared encoding with the generator side.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  // Parity mode selector values.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_check_rx.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop.
// Checks parity (even/odd) and stop bit, presents words on valid/ready.
module parity_check_rx
  import parity_check_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx,
  input  logic              odd_sel,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_e              state_q;
  logic [DATA_W-1:0]   shift_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                par_acc_q;
  logic                odd_q;
  logic                perr_pend_q;
  logic [DATA_W-1:0]   out_data_q;
  logic                out_valid_q;
  logic                perr_q;
  logic                ferr_q;
  logic                overrun_q;

  logic [DATA_W:0]     shift_ext_d;
  logic [DATA_W-1:0]   shift_d;
  logic                expected_par_d;

  // Right shift with rx entering at the MSB, so after DATA_W bits the first
  // received bit sits at position 0; built via a widened vector so DATA_W=1
  // needs no special case.
  always_comb begin
    shift_ext_d    = {rx, shift_q};
    shift_d        = shift_ext_d[DATA_W:1];
    expected_par_d = par_acc_q ^ (odd_q == PAR_ODD);
  end

  // Frame FSM, deserialiser and output holding register with handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      par_acc_q   <= 1'b0;
      odd_q       <= PAR_EVEN;
      perr_pend_q <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;

      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
        perr_q      <= 1'b0;
        ferr_q      <= 1'b0;
      end

      if (bit_en) begin
        unique case (state_q)
          IDLE: begin
            if (!rx) begin
              state_q   <= DATA;
              odd_q     <= odd_sel;
              cnt_q     <= '0;
              par_acc_q <= 1'b0;
              shift_q   <= '0;
            end
          end
          DATA: begin
            shift_q   <= shift_d;
            par_acc_q <= par_acc_q ^ rx;
            cnt_q     <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(DATA_W - 1)) state_q <= PARITY;
          end
          PARITY: begin
            perr_pend_q <= (rx != expected_par_d);
            state_q     <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            // A completion may reuse the slot being accepted this same cycle.
            if (!out_valid_q || out_ready) begin
              out_data_q  <= shift_q;
              perr_q      <= perr_pend_q;
              ferr_q      <= ~rx;
              out_valid_q <= 1'b1;
            end else begin
              overrun_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_parity_check_rx.sv
// Directed bench for parity_check_rx with DATA_W=4.
module tb_parity_check_rx;

  logic       clk;
  logic       rst_n;
  logic       bit_en;
  logic       rx;
  logic       odd_sel;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests_run;
  int tests_failed;

  parity_check_rx #(.DATA_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .rx         (rx),
    .odd_sel    (odd_sel),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobed bit, driven at a negedge; returns at the negedge after the
  // sampling posedge with bit_en and out_ready low again.
  task automatic send_bit(input logic b, input logic rdy);
    @(negedge clk);
    rx        = b;
    bit_en    = 1'b1;
    out_ready = rdy;
    @(negedge clk);
    bit_en    = 1'b0;
    out_ready = 1'b0;
  endtask

  // Start bit, data LSB first, parity bit; stop bit is sent by the caller.
  task automatic send_head(input logic [3:0] d, input logic p);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i], 1'b0);
    send_bit(p, 1'b0);
  endtask

  // Pulse out_ready for one cycle and check the slot empties.
  task automatic accept(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rx = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_accept: valid=%b perr=%b ferr=%b required 0 0 0", name, out_valid, parity_err, frame_err);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; rx = 1'b1; bit_en = 1'b0; odd_sel = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_data, out_valid, parity_err, frame_err, overrun, busy} !== 9'b0) begin
      tests_failed++;
      $display("FAIL reset: data=%h v=%b pe=%b fe=%b ov=%b busy=%b required all 0", out_data, out_valid, parity_err, frame_err, overrun, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_even_parity;
    odd_sel = 1'b0;
    send_head(4'hB, 1'b1);
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL even_prestop: valid=%b busy=%b required 0 1", out_valid, busy);
    end
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'hB || parity_err !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL even_word: v=%b data=%h pe=%b fe=%b busy=%b required 1 b 0 0 0", out_valid, out_data, parity_err, frame_err, busy);
    end
    accept("even");
  endtask

  task automatic test_odd_parity;
    odd_sel = 1'b1;
    send_head(4'h6, 1'b0);
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'h6 || parity_err !== 1'b1 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL odd_bad: v=%b data=%h pe=%b fe=%b required 1 6 1 0", out_valid, out_data, parity_err, frame_err);
    end
    accept("odd_bad");
    // odd_sel is dropped right after the start bit; the frame must stay odd.
    send_bit(1'b0, 1'b0);
    odd_sel = 1'b0;
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'h6 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL odd_good: v=%b data=%h pe=%b fe=%b required 1 6 0 0", out_valid, out_data, parity_err, frame_err);
    end
    accept("odd_good");
  endtask

  task automatic test_frame_err;
    odd_sel = 1'b0;
    send_head(4'hF, 1'b0);
    send_bit(1'b0, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'hF || parity_err !== 1'b0 || frame_err !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ferr_word: v=%b data=%h pe=%b fe=%b busy=%b required 1 f 0 1 0", out_valid, out_data, parity_err, frame_err, busy);
    end
    accept("ferr");
    send_head(4'h3, 1'b0);
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL ferr_rearm: v=%b data=%h pe=%b fe=%b required 1 3 0 0", out_valid, out_data, parity_err, frame_err);
    end
    accept("rearm");
  endtask

  task automatic test_overrun;
    send_head(4'h3, 1'b0);
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovr_first: v=%b data=%h ov=%b required 1 3 0", out_valid, out_data, overrun);
    end
    send_head(4'hC, 1'b0);
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (overrun !== 1'b1 || out_data !== 4'h3 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_pulse: ov=%b data=%h v=%b required 1 3 1", overrun, out_data, out_valid);
    end
    @(negedge clk);
    tests_run++;
    if (overrun !== 1'b0 || out_data !== 4'h3) begin
      tests_failed++;
      $display("FAIL ovr_width: ov=%b data=%h required 0 3", overrun, out_data);
    end
    accept("ovr");
  endtask

  task automatic test_mid_reset;
    send_head(4'h9, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre: busy=%b v=%b required 1 1", busy, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_data, out_valid, parity_err, frame_err, overrun, busy} !== 9'b0) begin
      tests_failed++;
      $display("FAIL rst_async: data=%h v=%b pe=%b fe=%b ov=%b busy=%b required all 0", out_data, out_valid, parity_err, frame_err, overrun, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_head(4'h5, 1'b0);
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'h5 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_next: v=%b data=%h pe=%b fe=%b required 1 5 0 0", out_valid, out_data, parity_err, frame_err);
    end
    accept("rst");
  endtask

  task automatic test_back_to_back;
    odd_sel = 1'b0;
    send_head(4'h1, 1'b1);
    send_bit(1'b1, 1'b0);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'h1) begin
      tests_failed++;
      $display("FAIL b2b_first: v=%b data=%h required 1 1", out_valid, out_data);
    end
    send_head(4'h2, 1'b1);
    send_bit(1'b1, 1'b1);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'h2 || overrun !== 1'b0 || parity_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_swap: v=%b data=%h ov=%b pe=%b required 1 2 0 0", out_valid, out_data, overrun, parity_err);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 4'h2) begin
      tests_failed++;
      $display("FAIL b2b_hold: v=%b data=%h required 1 2", out_valid, out_data);
    end
    accept("b2b");
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_frame_err();
    test_overrun();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule

// File: doc/parity_check_rx.md
Name: parity_check_rx

Overview:
Serial frame receiver that checks parity, the receiving end of the team's parity generator path. It takes a line carrying start bit, DATA_W data bits (LSB first), one parity bit and one stop bit, sampled on a bit-rate strobe. It deserialises the data, checks parity (even or odd, selectable) and the stop bit, and presents each word with error flags on a valid/ready output. It sits between the line-side bit timing logic, which supplies bit_en, and the consumer logic.

Parameters:
DATA_W, 4, data bits per frame; legal range 1..16.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
bit_en  input  1  one-cycle strobe; rx is sampled only in cycles where bit_en=1.
rx  input  1  serial line; idles high.
odd_sel  input  1  0 = even parity, 1 = odd parity; captured at start bit.
out_ready  input  1  consumer accepts out_data when high with out_valid.
out_data  output  DATA_W  received word.
out_valid  output  1  out_data and flags hold a received, unaccepted frame.
parity_err  output  1  parity mismatch for the word in out_data.
frame_err  output  1  stop bit was 0 for the word in out_data.
overrun  output  1  one-cycle pulse; a completed frame was dropped.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, shift/count/parity accumulators cleared; out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. A reset mid-frame aborts the frame with no output.
- All state changes occur only on bit_en cycles, except output handshake and overrun clearing.
- IDLE: bit_en & rx=0 -> DATA. Capture odd_sel, clear bit count and running parity. bit_en & rx=1 -> stay. rx activity without bit_en is ignored.
- DATA: each bit_en shifts rx in LSB first (bit i lands in position i) and does par_acc ^= rx. After the DATA_W-th bit -> PARITY.
- PARITY: on bit_en, expected = par_acc XOR captured odd_sel. Set perr_next = (rx != expected). Even: parity bit equals XOR of data. Odd: it equals XNOR. -> STOP.
- STOP: on bit_en, ferr_next = (rx==0), then -> IDLE. The frame completes in this cycle regardless of the stop value; no resync search.
- Completion, registered on the clock edge of the stop-sample cycle; outputs update the next cycle:
  - If out_valid=0, or out_valid & out_ready in the same cycle: load out_data, parity_err, frame_err; out_valid=1.
  - If out_valid=1 & out_ready=0: drop the new frame, hold existing outputs, overrun=1 for exactly one cycle.
- Handshake: out_valid stays high until out_ready is sampled high; then it clears next cycle unless a completion loads in the same cycle. parity_err and frame_err are valid only while out_valid=1 and are cleared on acceptance.
- A stop-bit frame_err does not block the next start: IDLE re-arms immediately. A line held low yields back-to-back frames with frame_err.
- Latency: stop sample (bit_en cycle) -> out_valid high 1 clk later.
- busy=1 from the start-bit edge through the STOP bit_en cycle.
- odd_sel changes mid-frame have no effect on the current frame.

Decomposition:
- Shared package: state encoding constants (IDLE, DATA, PARITY, STOP as 2-bit values) and the parity-mode constants (PAR_EVEN=0, PAR_ODD=1), both shared with the generator side.
- Bit counter width is $clog2(DATA_W+1), computed locally.
- No sub-module; the parity accumulator and shift register are inline.

Test Plan:
1. DATA_W=4, odd_sel=0, frame 0,1,1,0,1,1,1 (start, data LSB-first 1,1,0,1, parity 1, stop 1) -> out_valid 1 clk after stop; out_data=4'hB; parity_err=0; frame_err=0.
2. odd_sel=1, data 4'b0110 with parity bit 0 (expected 1), stop 1 -> out_data=4'h6, parity_err=1, frame_err=0. Repeat with parity 1 -> parity_err=0.
3. Even parity, data 4'hF, parity 0, stop bit 0 -> out_data=4'hF, parity_err=0, frame_err=1; next start bit still accepted.
4. out_ready=0, two valid frames 4'h3 then 4'hC -> out_data stays 4'h3, overrun pulses exactly 1 clk at the second completion. Raise out_ready -> out_valid drops next cycle.
5. rst_n pulsed low after 2 data bits of 4'hA -> all outputs 0, busy=0 immediately (async). Next frame 4'h5 is received correctly with no errors.
6. Completion coinciding with out_valid & out_ready (old 4'h1, new 4'h2) -> out_valid stays high, out_data=4'h2, no overrun.
